// File: rtl/regb_port_arbiter.sv
// Round-robin arbiter for register-file read port B: grants one of two requesters,
// registers its address onto rn2 and returns the read data with a per-requester valid.
module regb_port_arbiter #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          req0_i,
  input  logic [AW-1:0] addr0_i,
  input  logic          req1_i,
  input  logic [AW-1:0] addr1_i,
  input  logic          stall_i,
  input  logic [DW-1:0] rf_rdata_i,
  output logic          gnt0_o,
  output logic          gnt1_o,
  output logic          regb_o,
  output logic [AW-1:0] rn2_o,
  output logic          vld0_o,
  output logic          vld1_o,
  output logic [DW-1:0] rdata_o
);

  logic          gnt0_q, gnt0_d;
  logic          gnt1_q, gnt1_d;
  logic          regb_q, regb_d;
  logic [AW-1:0] rn2_q, rn2_d;
  logic          last_q, last_d;
  logic          issue_v_q, issue_v_d;
  logic          owner_q, owner_d;
  logic          vld0_q, vld0_d;
  logic          vld1_q, vld1_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic elig0, elig1, win1, issue;

  always_comb begin
    // A requester granted last cycle is masked so a held request is not granted twice.
    elig0 = req0_i & ~gnt0_q;
    elig1 = req1_i & ~gnt1_q;
    win1  = elig1 & (~elig0 | ~last_q);
    issue = ~stall_i & (elig0 | elig1);

    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    regb_d    = regb_q;
    rn2_d     = rn2_q;
    last_d    = last_q;
    issue_v_d = 1'b0;
    owner_d   = owner_q;

    if (issue) begin
      gnt0_d    = ~win1;
      gnt1_d    = win1;
      regb_d    = win1;
      rn2_d     = win1 ? addr1_i : addr0_i;
      last_d    = win1;
      issue_v_d = 1'b1;
      owner_d   = win1;
    end

    // Read data is valid one cycle after the address lands on rn2.
    vld0_d  = issue_v_q & ~owner_q;
    vld1_d  = issue_v_q & owner_q;
    rdata_d = issue_v_q ? rf_rdata_i : rdata_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      regb_q    <= 1'b0;
      rn2_q     <= '0;
      last_q    <= 1'b1;
      issue_v_q <= 1'b0;
      owner_q   <= 1'b0;
      vld0_q    <= 1'b0;
      vld1_q    <= 1'b0;
      rdata_q   <= '0;
    end else begin
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      regb_q    <= regb_d;
      rn2_q     <= rn2_d;
      last_q    <= last_d;
      issue_v_q <= issue_v_d;
      owner_q   <= owner_d;
      vld0_q    <= vld0_d;
      vld1_q    <= vld1_d;
      rdata_q   <= rdata_d;
    end
  end

  assign gnt0_o  = gnt0_q;
  assign gnt1_o  = gnt1_q;
  assign regb_o  = regb_q;
  assign rn2_o   = rn2_q;
  assign vld0_o  = vld0_q;
  assign vld1_o  = vld1_q;
  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_regb_port_arbiter.sv
// Directed table-driven bench for regb_port_arbiter with a small register-file
// model driving rf_rdata from rn2; reset-mid-flight is a hand-written sequence.
module tb_regb_port_arbiter;

  logic       clk = 1'b0;
  logic       rst_n, stall, req0, req1;
  logic [3:0] addr0, addr1, rn2;
  logic [7:0] rf_rdata, rdata;
  logic       gnt0, gnt1, regb, vld0, vld1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Register file contents: data at address a is {a,a} ^ 8'h96 (address 10 -> 8'h3C).
  function automatic logic [7:0] rf_model(input logic [3:0] a);
    return {a, a} ^ 8'h96;
  endfunction

  assign rf_rdata = rf_model(rn2);

  regb_port_arbiter #(.AW(4), .DW(8)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .req0_i    (req0),
    .addr0_i   (addr0),
    .req1_i    (req1),
    .addr1_i   (addr1),
    .stall_i   (stall),
    .rf_rdata_i(rf_rdata),
    .gnt0_o    (gnt0),
    .gnt1_o    (gnt1),
    .regb_o    (regb),
    .rn2_o     (rn2),
    .vld0_o    (vld0),
    .vld1_o    (vld1),
    .rdata_o   (rdata)
  );

  typedef struct {
    logic       rst_n, stall, req0;
    logic [3:0] addr0;
    logic       req1;
    logic [3:0] addr1;
    logic       g0, g1, rb;
    logic [3:0] rn;
    logic       v0, v1;
    logic [7:0] rd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, s, q0, input logic [3:0] a0, input logic q1,
                     input logic [3:0] a1, input logic g0, g1, rb,
                     input logic [3:0] rn, input logic v0, v1, input logic [7:0] rd);
    vec_t v;
    v.rst_n = r;  v.stall = s;  v.req0 = q0; v.addr0 = a0; v.req1 = q1; v.addr1 = a1;
    v.g0 = g0; v.g1 = g1; v.rb = rb; v.rn = rn; v.v0 = v0; v.v1 = v1; v.rd = rd;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%h required=%h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, s, q0, input logic [3:0] a0, input logic q1, input logic [3:0] a1);
    rst_n = r; stall = s; req0 = q0; addr0 = a0; req1 = q1; addr1 = a1;
  endtask

  task automatic check_out(input int idx, input logic g0, g1, rb, input logic [3:0] rn,
                           input logic v0, v1, input logic [7:0] rd);
    chk("gnt0", idx, {7'd0, gnt0}, {7'd0, g0});
    chk("gnt1", idx, {7'd0, gnt1}, {7'd0, g1});
    chk("regB", idx, {7'd0, regb}, {7'd0, rb});
    chk("rn2", idx, {4'd0, rn2}, {4'd0, rn});
    chk("vld0", idx, {7'd0, vld0}, {7'd0, v0});
    chk("vld1", idx, {7'd0, vld1}, {7'd0, v1});
    chk("rdata", idx, rdata, rd);
    chk("gnt_excl", idx, {7'd0, gnt0 & gnt1}, 8'd0);
    chk("vld_excl", idx, {7'd0, vld0 & vld1}, 8'd0);
    $display("step %0d: gnt=%b%b regB=%b rn2=%h vld=%b%b rdata=%h", idx, gnt1, gnt0, regb, rn2, vld1, vld0, rdata);
  endtask

  // Apply inputs on the falling edge, sample outputs 1 time unit after the rising edge.
  task automatic step(input int idx, input logic r, s, q0, input logic [3:0] a0, input logic q1,
                      input logic [3:0] a1, input logic g0, g1, rb, input logic [3:0] rn,
                      input logic v0, v1, input logic [7:0] rd);
    @(negedge clk);
    drive(r, s, q0, a0, q1, a1);
    @(posedge clk);
    #1;
    check_out(idx, g0, g1, rb, rn, v0, v1, rd);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);

    // rst stall r0 a0 r1 a1 | g0 g1 rb rn v0 v1 rdata
    add(0,0,0,4'h0,0,4'h0, 0,0,0,4'h0,0,0,8'h00);  // reset
    add(0,0,0,4'h0,0,4'h0, 0,0,0,4'h0,0,0,8'h00);
    add(1,0,1,4'hA,0,4'h0, 1,0,0,4'hA,0,0,8'h00);  // single request
    add(1,0,0,4'h0,0,4'h0, 0,0,0,4'hA,1,0,8'h3C);
    add(1,0,0,4'h0,0,4'h0, 0,0,0,4'hA,0,0,8'h3C);
    add(0,0,0,4'h0,0,4'h0, 0,0,0,4'h0,0,0,8'h00);  // re-reset before tie test
    add(1,0,1,4'hA,1,4'hD, 1,0,0,4'hA,0,0,8'h00);  // simultaneous requests
    add(1,0,0,4'h0,1,4'hD, 0,1,1,4'hD,1,0,8'h3C);
    add(1,0,0,4'h0,0,4'h0, 0,0,1,4'hD,0,1,8'h4B);
    add(1,0,1,4'h3,1,4'h5, 1,0,0,4'h3,0,0,8'h4B);  // round-robin, both held
    add(1,0,1,4'h6,1,4'h5, 0,1,1,4'h5,1,0,8'hA5);
    add(1,0,1,4'h6,1,4'h9, 1,0,0,4'h6,0,1,8'hC3);
    add(1,0,1,4'hC,1,4'h9, 0,1,1,4'h9,1,0,8'hF0);
    add(1,0,1,4'hC,1,4'h1, 1,0,0,4'hC,0,1,8'h0F);
    add(1,0,1,4'h2,1,4'h1, 0,1,1,4'h1,1,0,8'h5A);
    add(1,0,1,4'h2,1,4'h7, 1,0,0,4'h2,0,1,8'h87);
    add(1,0,0,4'h0,1,4'h7, 0,1,1,4'h7,1,0,8'hB4);
    add(1,0,0,4'h0,0,4'h0, 0,0,1,4'h7,0,1,8'hE1);
    add(1,1,0,4'h0,1,4'hD, 0,0,1,4'h7,0,0,8'hE1);  // stall holds pending req1
    add(1,1,0,4'h0,1,4'hD, 0,0,1,4'h7,0,0,8'hE1);
    add(1,1,0,4'h0,1,4'hD, 0,0,1,4'h7,0,0,8'hE1);
    add(1,0,0,4'h0,1,4'hD, 0,1,1,4'hD,0,0,8'hE1);
    add(1,0,0,4'h0,0,4'h0, 0,0,1,4'hD,0,1,8'h4B);
    add(1,0,1,4'h5,0,4'h0, 1,0,0,4'h5,0,0,8'h4B);  // stall during in-flight read
    add(1,1,0,4'h0,1,4'h3, 0,0,0,4'h5,1,0,8'hC3);
    add(1,1,0,4'h0,1,4'h3, 0,0,0,4'h5,0,0,8'hC3);
    add(1,0,0,4'h0,1,4'h3, 0,1,1,4'h3,0,0,8'hC3);
    add(1,0,0,4'h0,0,4'h0, 0,0,1,4'h3,0,1,8'hA5);

    foreach (vecs[i]) begin
      step(i, vecs[i].rst_n, vecs[i].stall, vecs[i].req0, vecs[i].addr0, vecs[i].req1, vecs[i].addr1,
           vecs[i].g0, vecs[i].g1, vecs[i].rb, vecs[i].rn, vecs[i].v0, vecs[i].v1, vecs[i].rd);
    end

    // Reset while a req1 read is in flight: no vld1 afterwards, then req0 wins the tie.
    step(100, 1,0,0,4'h0,1,4'h9, 0,1,1,4'h9,0,0,8'hA5);
    step(101, 0,0,0,4'h0,0,4'h0, 0,0,0,4'h0,0,0,8'h00);
    step(102, 1,0,0,4'h0,0,4'h0, 0,0,0,4'h0,0,0,8'h00);
    step(103, 1,0,1,4'hC,1,4'h6, 1,0,0,4'hC,0,0,8'h00);
    step(104, 1,0,0,4'h0,1,4'h6, 0,1,1,4'h6,1,0,8'h5A);
    step(105, 1,0,0,4'h0,0,4'h0, 0,0,1,4'h6,0,1,8'hF0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regb_port_arbiter.md
Name: regb_port_arbiter

Overview:
- Round-robin arbiter and sequencer for register-file read port B.
- Shares the read-port-B address mux (select regB, output rn2) between two requesters: requester 0 drives mux input in0, requester 1 drives in1.
- Registers the winning address onto rn2, captures the combinational register-file read data one cycle later, and returns it with a per-requester valid pulse.
- Sits between decode/issue logic and the mux_reg_B / register-file read-port-B path.

Parameters:
- AW, 4, register address width (16 architectural registers)
- DW, 8, register data width

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- req0  input  1  requester 0 read request; held with addr0 stable until gnt0
- addr0  input  AW  requester 0 register address
- req1  input  1  requester 1 read request; held with addr1 stable until gnt1
- addr1  input  AW  requester 1 register address
- stall  input  1  when high, no new grant is issued
- rf_rdata  input  DW  register-file read-port-B data, combinational from rn2
- gnt0  output  1  one-cycle grant pulse to requester 0
- gnt1  output  1  one-cycle grant pulse to requester 1
- regB  output  1  mux select: 0 = in0/addr0, 1 = in1/addr1
- rn2  output  AW  registered read address to register file port B
- vld0  output  1  one-cycle response-valid pulse to requester 0
- vld1  output  1  one-cycle response-valid pulse to requester 1
- rdata  output  DW  captured read data, meaningful while vld0 or vld1 is high

Behaviour:
- The interface uses one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values:
  - gnt0, gnt1, vld0, vld1 = 0
  - regB = 0, rn2 = 0, rdata = 0
  - internal issue_v = 0
  - priority pointer last = 1, so requester 0 wins the first tie.
- Eligibility in cycle t: reqX=1 and gntX=0. A requester granted in the previous cycle is masked for one cycle, so it can never be double-granted on a held req.
- Arbitration in cycle t (only when stall=0 and at least one requester is eligible):
  - Exactly one eligible: that requester wins.
  - Both eligible: the requester not equal to last wins.
- Issue (edge ending cycle t): for winner X,
  - gntX <= 1 for exactly one cycle
  - regB <= X
  - rn2 <= addrX
  - last <= X
  - issue_v <= 1, owner <= X
- Otherwise: gnt0/gnt1 <= 0, issue_v <= 0. regB and rn2 hold their previous values (no spurious address toggling).
- Capture (edge ending cycle t+1): if issue_v=1,
  - rdata <= rf_rdata
  - vld[owner] <= 1 for one cycle
  - Otherwise vld0 and vld1 are 0 and rdata holds.
- Latency: request sampled in cycle t → gnt in t+1 → vld and rdata in t+2.
- Pipelined throughput: one issue per cycle when both requesters alternate; a single requester gets at most one grant every 2 cycles.
- stall:
  - Blocks new issue only.
  - An in-flight issue (issue_v=1) still produces its vld on the next edge.
  - Requests stay pending and are arbitrated on the first cycle with stall=0.
- At most one of gnt0/gnt1 is high in any cycle; the same holds for vld0/vld1.
- rst_n low mid-operation clears issue_v, so no vld is emitted for an in-flight read; all outputs return to reset values on that edge.
- Widths: rn2 equals the selected addr exactly (no arithmetic). rdata is a DW-bit copy of rf_rdata.

Test Plan:
1. Reset then single request: rst_n=0 for 2 cycles, then req0=1, addr0=4'b1010, rf_rdata model = 8'h3C at address 10 → gnt0 next cycle with regB=0, rn2=4'b1010; the following cycle vld0=1, rdata=8'h3C, vld1=0.
2. Simultaneous requests: req0=1/addr0=4'b1010 and req1=1/addr1=4'b1101, both held until granted → gnt0 in cycle 1 (rn2=1010, regB=0), gnt1 in cycle 2 (rn2=1101, regB=1); vld0 in cycle 2, vld1 in cycle 3, each with the matching rf_rdata.
3. Round-robin fairness: req0 and req1 held high for 8 cycles with new addresses after each grant → grants alternate 0,1,0,1…; no requester is granted twice in a row while the other is pending.
4. Stall: req1=1, addr1=4'b1101, stall=1 for 3 cycles then 0 → no gnt1 while stalled and rn2 unchanged; gnt1 on the first edge after stall falls; vld1 one cycle later.
5. Stall during in-flight read: gnt0 issued, stall asserted in the same cycle → vld0 still pulses the next cycle with correct rdata; no new grant until stall=0.
6. Reset mid-operation: gnt1 high (read in flight), rst_n=0 that cycle → no vld1 afterwards; regB=0, rn2=0, all pulses 0; after release, req0 wins the first tie.
